t_state_sequencer: RTL and testbench
====================================

// Module: t_state_sequencer
// PURPOSE
//  Parametrised instruction-cycle timing generator for the core dispatch path: one-hot T-state ring with
//  early termination (TWOCYCLE/ENDS), short-cycle skip and a configurable read-modify-write tail.
//  It also handles the RDY stall, an ACR latch and the fetch/IR-inject/PC-increment strobes.
//  Sits between decode (X outputs) and random logic; replaces fixed T0..T5 + T6/T7 logic with one generic block.
// PARAMETERS
//  MAX_T    6  number of base T-states T0..T(MAX_T-1); legal 3..8
//  RMW_CYC  2  extra RMW tail states R0..R(RMW_CYC-1) inserted before T0; legal 0..3 (0 = no tail)
//  CNT_W    4  width of per-instruction cycle counter CYC
// PORTS
//  PHI0      in   1          single core clock, all state updates on rising edge
//  RES       in   1          asynchronous active-high reset
//  RDY       in   1          ready; 0 stalls all state except on write cycles
//  WR_CYCLE  in   1          current cycle is a bus write (RDY ignored)
//  TWOCYCLE  in   1          instruction completes after T1 (T1 -> T0)
//  ENDS      in   1          instruction ends in current Tk (k>=2): next state T0 (or RMW tail)
//  SKIP      in   1          short cycle: Tk advances to Tk+2 (no index carry)
//  RMW       in   1          current instruction is read-modify-write; ENDS enters tail
//  ACR       in   1          ALU carry to latch
//  B_OUT     in   1          interrupt pending: inject BRK on fetch
//  IPC_REQ   in   1          decode requests PC increment this cycle
//  T         out  MAX_T      one-hot base T-state, T[0]=T0
//  RT        out  max(RMW_CYC,1)  one-hot RMW tail state (all 0 when RMW_CYC=0)
//  NOT_READY out  1          registered stall flag (~RDY & ~WR_CYCLE) from previous edge
//  ACRL      out  1          latched ACR
//  FETCH     out  1          opcode fetch strobe
//  Z_IR      out  1          clear IR (force BRK) on this fetch
//  IPC       out  1          increment PC this cycle
//  CYC       out  CNT_W      cycles since T1 of current instruction, saturating
//  TOVF      out  1          sticky: base sequence ran past T(MAX_T-1) without ENDS
// BEHAVIOUR
//  Reset (async, immediate): T=one-hot T0, RT=0, NOT_READY=0, ACRL=0, CYC=0, TOVF=0; comb strobes follow.
//  adv = RDY | WR_CYCLE. adv=0: T, RT, ACRL, CYC hold; NOT_READY<=1. adv=1: NOT_READY<=0, state steps:
//   T0 -> T1.  T1 -> T0 if TWOCYCLE else T2.
//   Tk (2<=k<MAX_T): ENDS&RMW&RMW_CYC>0 -> R0; ENDS -> T0; SKIP&k+2<MAX_T -> T(k+2); k<MAX_T-1 -> T(k+1);
//   else (k=MAX_T-1, no ENDS) -> T0 and TOVF<=1. Priority: ENDS > SKIP > step. SKIP past end = step.
//   Rj -> R(j+1); R(RMW_CYC-1) -> T0. ENDS/SKIP/TWOCYCLE ignored in tail and in T0.
//  Exactly one of {T,RT} bits set at all times; illegal encoding (any other) recovers to T0 next edge.
//  ACRL <= ACR when adv, else hold. TOVF clears only on RES.
//  CYC: <=0 on entry to T1; else +1 per advancing edge, saturates at 2^CNT_W-1; holds on stall.
//  Comb: FETCH = T[1] & adv; Z_IR = FETCH & B_OUT; IPC = adv & ((FETCH & ~B_OUT) | IPC_REQ).
//  Stall on write cycle: WR_CYCLE=1 advances regardless of RDY. A write cycle never stalls.
//  RDY drop in T1: FETCH=0 that cycle; fetch repeats when RDY returns (one FETCH per T1 exit).
//  Simultaneous TWOCYCLE & ENDS in T1: TWOCYCLE governs (ENDS only for k>=2).
//  RES mid-instruction or mid-tail: immediate return to T0, tail abandoned.
// TESTING
//  Release RES, RDY=1, TWOCYCLE=1 forever -> T sequence T0,T1,T0,T1..., FETCH high each T1, CYC 0,1,0..
//  MAX_T=6, ENDS at T4 -> T0,T1,T2,T3,T4,T0; CYC=3 at T4; TOVF stays 0.
//  RMW=1, ENDS at T3, RMW_CYC=2 -> T3,R0,R1,T0; RT one-hot during tail, T=0 there.
//  RDY=0 for 3 cycles at T2 (WR_CYCLE=0) -> T2 held 3 edges, NOT_READY=1 one cycle later, ACRL unchanged;
//   same with WR_CYCLE=1 -> advances to T3.
//  SKIP at T2 -> T4; SKIP at T4 (MAX_T=6) -> T5; no ENDS at T5 -> T0 and TOVF=1 until RES.
//  B_OUT=1 in T1 -> Z_IR=1, IPC=0; RES asserted in R0 -> T0 same cycle, all outputs at reset values.

Source files
------------

// File: rtl/t_state_sequencer.sv
// t_state_sequencer
// Instruction-cycle timing generator for the core dispatch path.
// It has a one-hot base T-state ring T0..T(MAX_T-1) and an optional one-hot
// read-modify-write tail R0..R(RMW_CYC-1) that runs between the end of an
// instruction and the next T0. It also produces the RDY stall flag, the
// latched ALU carry, and the fetch, IR-inject and PC-increment strobes.
// Exactly one bit of {t, rt} is set at any time. Any other encoding returns
// to T0 on the next clock edge.

module t_state_sequencer #(
  parameter int  MAX_T   = 6,   // base T-states T0..T(MAX_T-1), 3..8
  parameter int  RMW_CYC = 2,   // RMW tail length, 0..3 (0 = no tail)
  parameter int  CNT_W   = 4,   // width of the per-instruction cycle counter
  localparam int RT_W    = (RMW_CYC > 0) ? RMW_CYC : 1
) (
  input  logic             phi0,       // core clock, rising edge
  input  logic             res,        // asynchronous active-high reset
  input  logic             rdy,        // 0 stalls, except on write cycles
  input  logic             wr_cycle,   // bus write: never stalls
  input  logic             twocycle,   // instruction completes after T1
  input  logic             ends,       // instruction ends in current Tk, k>=2
  input  logic             skip,       // short cycle: Tk -> Tk+2
  input  logic             rmw,        // read-modify-write: ENDS enters tail
  input  logic             acr,        // ALU carry
  input  logic             b_out,      // interrupt pending: inject BRK
  input  logic             ipc_req,    // decode requests a PC increment
  output logic [MAX_T-1:0] t,          // one-hot base T-state, t[0] = T0
  output logic [RT_W-1:0]  rt,         // one-hot RMW tail state
  output logic             not_ready,  // stall seen on the previous edge
  output logic             acrl,       // latched ALU carry
  output logic             fetch,      // opcode fetch strobe
  output logic             z_ir,       // clear IR (force BRK) on this fetch
  output logic             ipc,        // increment PC this cycle
  output logic [CNT_W-1:0] cyc,        // cycles since T1, saturating
  output logic             tovf        // sticky: ran off the end of the ring
);

  localparam logic [MAX_T-1:0] T0_ONEHOT = MAX_T'(1);
  localparam logic [CNT_W-1:0] CYC_MAX   = {CNT_W{1'b1}};
  localparam int               RT_LAST   = RT_W - 1;

  logic             adv;      // the state machine steps on this edge
  logic             legal;    // exactly one state bit is set
  logic             in_tail;  // currently in the RMW tail
  logic [MAX_T-1:0] t_nxt;
  logic [RT_W-1:0]  rt_nxt;
  logic             ovf_set;

  // A write cycle always advances. Otherwise the ring waits for RDY.
  assign adv     = rdy | wr_cycle;
  assign legal   = ($countones({t, rt}) == 1);
  assign in_tail = |rt;

  // Combinational strobes decoded from the current state and this cycle's inputs.
  assign fetch = t[1] & adv;
  assign z_ir  = fetch & b_out;
  assign ipc   = adv & ((fetch & ~b_out) | ipc_req);

  // Next-state decode for the T ring and the RMW tail.
  // The priority order inside Tk is ENDS, then SKIP, then a plain step.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    t_nxt   = t;
    rt_nxt  = rt;
    ovf_set = 1'b0;

    if (!legal) begin
      t_nxt  = T0_ONEHOT;
      rt_nxt = '0;
    end else if (adv) begin
      t_nxt  = '0;
      rt_nxt = '0;
      if (in_tail) begin
        // The tail walks R0..R(last), then returns to T0. Decode inputs are ignored here.
        if (rt[RT_LAST]) t_nxt[0] = 1'b1;
        else             rt_nxt   = rt << 1;
      end else if (t[0]) begin
        t_nxt[1] = 1'b1;
      end else if (t[1]) begin
        if (twocycle) t_nxt[0] = 1'b1;
        else          t_nxt[2] = 1'b1;
      end else begin
        // Tk with k >= 2
        if (ends) begin
          if (rmw && (RMW_CYC > 0)) rt_nxt[0] = 1'b1;
          else                      t_nxt[0]  = 1'b1;
        end else if (skip && !t[MAX_T-1] && !t[MAX_T-2]) begin
          // Skip only while T(k+2) exists. Near the end it falls back to a step.
          t_nxt = t << 2;
        end else if (!t[MAX_T-1]) begin
          t_nxt = t << 1;
        end else begin
          // The ring ran past its last state without ENDS.
          t_nxt[0] = 1'b1;
          ovf_set  = 1'b1;
        end
      end
    end

    // A design built without a tail keeps rt permanently clear.
    if (RMW_CYC == 0) rt_nxt = '0;
  end

  // Registered state, stall flag, carry latch, cycle counter and overflow flag.
  always_ff @(posedge phi0 or posedge res) begin
    if (res) begin
      t         <= T0_ONEHOT;
      rt        <= '0;
      not_ready <= 1'b0;
      acrl      <= 1'b0;
      cyc       <= '0;
      tovf      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      t         <= t_nxt;
      rt        <= rt_nxt;
      not_ready <= ~adv;
      if (adv) begin
        acrl <= acr;
        if (t_nxt[1])            cyc <= '0;
        else if (cyc != CYC_MAX) cyc <= cyc + 1'b1;
      end
      if (ovf_set) tovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_t_state_sequencer.sv
// tb_t_state_sequencer
// Random-stimulus bench for t_state_sequencer with a scoreboard. At each
// cycle the driver steps an index-based reference model and pushes the
// expected outputs into a queue. A separate monitor pops one entry per
// falling edge and compares it with the DUT outputs.

module tb_t_state_sequencer;

  localparam int MAX_T   = 6;
  localparam int RMW_CYC = 2;
  localparam int CNT_W   = 2;   // narrow, so that counter saturation is reachable
  localparam int RT_W    = 2;
  localparam int N_CYC   = 3000;
  localparam int CYC_MAX = (1 << CNT_W) - 1;

  logic             phi0 = 1'b0;
  logic             res, rdy, wr_cycle, twocycle, ends, skip, rmw, acr, b_out, ipc_req;
  logic [MAX_T-1:0] t;
  logic [RT_W-1:0]  rt;
  logic             not_ready, acrl, fetch, z_ir, ipc, tovf;
  logic [CNT_W-1:0] cyc;

  t_state_sequencer #(.MAX_T(MAX_T), .RMW_CYC(RMW_CYC), .CNT_W(CNT_W)) dut (
    .phi0(phi0), .res(res), .rdy(rdy), .wr_cycle(wr_cycle), .twocycle(twocycle),
    .ends(ends), .skip(skip), .rmw(rmw), .acr(acr), .b_out(b_out), .ipc_req(ipc_req),
    .t(t), .rt(rt), .not_ready(not_ready), .acrl(acrl), .fetch(fetch), .z_ir(z_ir),
    .ipc(ipc), .cyc(cyc), .tovf(tovf)
  );

  always #5 phi0 = ~phi0;

  typedef struct {
    logic [MAX_T-1:0] t;
    logic [RT_W-1:0]  rt;
    logic             nr, acrl, fetch, z_ir, ipc, tovf;
    logic [CNT_W-1:0] cyc;
    int               n;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: the current state is (in tail?, index), plus the registered flags.
  bit m_tail;
  int m_k;
  bit m_nr, m_acrl, m_tovf;
  int m_cyc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want, input int n);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %0h want %0h", name, n, got, want);
    end
  endtask

  task automatic model_reset();
    m_tail = 0; m_k = 0; m_nr = 0; m_acrl = 0; m_tovf = 0; m_cyc = 0;
  endtask

  // One rising edge, using the inputs that were present at that edge.
  task automatic model_edge();
    bit a;
    if (res) begin
      model_reset();
      return;
    end
    a    = rdy | wr_cycle;
    m_nr = !a;
    if (!a) return;
    m_acrl = acr;
    if (m_tail) begin
      if (m_k == RMW_CYC - 1) begin m_tail = 0; m_k = 0; end
      else m_k++;
    end else if (m_k == 0)           m_k = 1;
    else if (m_k == 1)               m_k = twocycle ? 0 : 2;
    else if (ends) begin
      if (rmw && RMW_CYC > 0) begin m_tail = 1; m_k = 0; end
      else m_k = 0;
    end else if (skip && m_k + 2 < MAX_T) m_k += 2;
    else if (m_k < MAX_T - 1)        m_k++;
    else begin m_k = 0; m_tovf = 1; end
    if (!m_tail && m_k == 1)  m_cyc = 0;
    else if (m_cyc < CYC_MAX) m_cyc++;
  endtask

  function automatic exp_t expect_now(input int n);
    exp_t e;
    bit   a;
    a       = rdy | wr_cycle;
    e.t     = m_tail ? '0 : MAX_T'(1 << m_k);
    e.rt    = m_tail ? RT_W'(1 << m_k) : '0;
    e.nr    = m_nr;
    e.acrl  = m_acrl;
    e.tovf  = m_tovf;
    e.cyc   = CNT_W'(m_cyc);
    e.fetch = !m_tail && (m_k == 1) && a;
    e.z_ir  = e.fetch && b_out;
    e.ipc   = a && ((e.fetch && !b_out) || ipc_req);
    e.n     = n;
    return e;
  endfunction

  function automatic logic pct(input int p);
    return ($urandom_range(99) < p);
  endfunction

  // Driver: steps the model on each rising edge, then applies new inputs and pushes the expected outputs.
  initial begin
    res = 1'b1; rdy = 1'b1; wr_cycle = 1'b0; twocycle = 1'b0; ends = 1'b0; skip = 1'b0;
    rmw = 1'b0; acr = 1'b0; b_out = 1'b0; ipc_req = 1'b0;
    model_reset();
    #1;
    check("reset_t",    32'(t),         32'd1, -1);
    check("reset_rt",   32'(rt),        32'd0, -1);
    check("reset_cyc",  32'(cyc),       32'd0, -1);
    check("reset_tovf", 32'(tovf),      32'd0, -1);
    check("reset_nr",   32'(not_ready), 32'd0, -1);
    check("reset_acrl", 32'(acrl),      32'd0, -1);
    repeat (2) @(posedge phi0);
    #1;
    for (int n = 0; n < N_CYC; n++) begin
      if (n > 0) begin
        @(posedge phi0);
        model_edge();
        #1;
      end
      // Reset is rare in general, but likely inside R0 so that tail abandonment is exercised.
      res      = (m_tail && m_k == 0) ? pct(30) : pct(2);
      rdy      = pct(80);
      wr_cycle = pct(15);
      twocycle = pct(25);
      ends     = pct(30);
      skip     = pct(25);
      rmw      = pct(50);
      acr      = pct(50);
      b_out    = pct(20);
      ipc_req  = pct(25);
      if (res) model_reset();
      sb.push_back(expect_now(n));
    end
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge phi0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0, N_CYC);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: compares the DUT outputs against the oldest expectation, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge phi0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("t",         32'(t),         32'(e.t),     e.n);
        check("rt",        32'(rt),        32'(e.rt),    e.n);
        check("not_ready", 32'(not_ready), 32'(e.nr),    e.n);
        check("acrl",      32'(acrl),      32'(e.acrl),  e.n);
        check("fetch",     32'(fetch),     32'(e.fetch), e.n);
        check("z_ir",      32'(z_ir),      32'(e.z_ir),  e.n);
        check("ipc",       32'(ipc),       32'(e.ipc),   e.n);
        check("cyc",       32'(cyc),       32'(e.cyc),   e.n);
        check("tovf",      32'(tovf),      32'(e.tovf),  e.n);
      end
    end
  end

endmodule
